// File: rtl/fpu_addsub_arbiter_if.sv
// fpu_addsub_arbiter_if: request/issue/result bus of the shared FP add/sub arbiter.
// Requesters and the datapath model sit on the master side, the arbiter on the slave side.
// Signals in the I_ and O_ groups are named from the arbiter's point of view.
interface fpu_addsub_arbiter_if #(
    parameter int PRECISION = 32,
    parameter int NUM_REQ   = 4
);
    localparam int EW  = (PRECISION == 64) ? 11 : 8;
    localparam int MW  = (PRECISION == 64) ? 52 : 23;
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        I_Req_Valid;
    logic [NUM_REQ-1:0]        O_Req_Ready;
    logic [NUM_REQ-1:0]        I_Req_Sub;
    logic [NUM_REQ*EW-1:0]     I_Req_Exp;
    logic [NUM_REQ-1:0]        I_Req_Sign_Op1;
    logic [NUM_REQ*(MW+1)-1:0] I_Req_Mant_Op1;
    logic [NUM_REQ-1:0]        I_Req_Sign_Op2;
    logic [NUM_REQ*(MW+1)-1:0] I_Req_Mant_Op2;

    logic                      O_Dp_Valid;
    logic [EW-1:0]             O_Dp_Exp;
    logic                      O_Dp_Sign_Op1;
    logic [MW:0]               O_Dp_Mant_Op1;
    logic                      O_Dp_Sign_Op2;
    logic [MW:0]               O_Dp_Mant_Op2;

    logic                      I_Dp_Valid;
    logic                      I_Dp_Sign;
    logic [EW-1:0]             I_Dp_Exp;
    logic [MW+1:0]             I_Dp_Mant;

    logic [NUM_REQ-1:0]        O_Rsp_Valid;
    logic [IDW-1:0]            O_Rsp_Id;
    logic                      O_Rsp_Sign;
    logic [EW-1:0]             O_Rsp_Exp;
    logic [MW+1:0]             O_Rsp_Mant;
    logic                      O_Err;

    modport master (
        output I_Req_Valid, I_Req_Sub, I_Req_Exp, I_Req_Sign_Op1, I_Req_Mant_Op1,
               I_Req_Sign_Op2, I_Req_Mant_Op2,
               I_Dp_Valid, I_Dp_Sign, I_Dp_Exp, I_Dp_Mant,
        input  O_Req_Ready,
               O_Dp_Valid, O_Dp_Exp, O_Dp_Sign_Op1, O_Dp_Mant_Op1, O_Dp_Sign_Op2, O_Dp_Mant_Op2,
               O_Rsp_Valid, O_Rsp_Id, O_Rsp_Sign, O_Rsp_Exp, O_Rsp_Mant, O_Err
    );

    modport slave (
        input  I_Req_Valid, I_Req_Sub, I_Req_Exp, I_Req_Sign_Op1, I_Req_Mant_Op1,
               I_Req_Sign_Op2, I_Req_Mant_Op2,
               I_Dp_Valid, I_Dp_Sign, I_Dp_Exp, I_Dp_Mant,
        output O_Req_Ready,
               O_Dp_Valid, O_Dp_Exp, O_Dp_Sign_Op1, O_Dp_Mant_Op1, O_Dp_Sign_Op2, O_Dp_Mant_Op2,
               O_Rsp_Valid, O_Rsp_Id, O_Rsp_Sign, O_Rsp_Exp, O_Rsp_Mant, O_Err
    );
endinterface

// File: rtl/fpu_addsub_arbiter.sv
// fpu_addsub_arbiter: round-robin sharing of one FP add/sub datapath among NUM_REQ requesters,
// with per-requester credit limits and a tag pipe that routes each result back to its issuer.
// Optional build macro FPU_ARB_BUSY_CNT_EN adds saturating O_Busy_Cnt / O_Stall_Cnt outputs.
module fpu_addsub_arbiter #(
    parameter int PRECISION       = 32,
    parameter int NUM_REQ         = 4,
    parameter int DP_LATENCY      = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                I_Clk,
    input  logic                I_nReset,
    fpu_addsub_arbiter_if.slave bus
`ifdef FPU_ARB_BUSY_CNT_EN
    ,
    output logic [31:0]         O_Busy_Cnt,
    output logic [31:0]         O_Stall_Cnt
`endif
);
    localparam int EW  = (PRECISION == 64) ? 11 : 8;
    localparam int MW  = (PRECISION == 64) ? 52 : 23;
    localparam int MNW = MW + 1;
    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [3:0]     MAX_OS   = 4'(MAX_OUTSTANDING);
    localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

    logic [3:0]           r_cnt [NUM_REQ];
    logic [IDW-1:0]       r_rr_ptr;
    logic [IDW-1:0]       r_dp_id;
    logic [DP_LATENCY-1:0] r_tag_vld;
    logic [IDW-1:0]       r_tag_id [DP_LATENCY];

    logic [NUM_REQ-1:0]   w_eligible;
    logic [NUM_REQ-1:0]   w_grant;
    logic [NUM_REQ-1:0]   w_rsp_hit;
    logic                 w_found;
    logic [IDW-1:0]       w_grant_id;
    logic [IDW:0]         w_sum;
    logic [IDW-1:0]       w_idx;
    logic                 w_tag_vld;
    logic [IDW-1:0]       w_tag_id;
    logic                 w_rsp;

    assign w_tag_vld = r_tag_vld[DP_LATENCY-1];
    assign w_tag_id  = r_tag_id[DP_LATENCY-1];
    assign w_rsp     = bus.I_Dp_Valid && w_tag_vld;

    // Round-robin pick of the first eligible requester at or after the pointer.
    // Ready is held low while reset is asserted so no accept can be signalled then.
    always_comb begin
        w_eligible = '0;
        w_grant    = '0;
        w_found    = 1'b0;
        w_grant_id = '0;
        w_sum      = '0;
        w_idx      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = bus.I_Req_Valid[i] && (r_cnt[i] < MAX_OS);
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_sum >= NREQ_W) begin
                w_sum = w_sum - NREQ_W;
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_found && w_eligible[w_idx]) begin
                w_found    = 1'b1;
                w_grant_id = w_idx;
            end
        end
        if (w_found && I_nReset) begin
            w_grant[w_grant_id] = 1'b1;
        end
    end

    assign bus.O_Req_Ready = w_grant;

    // One-hot of the requester whose result is being accepted this cycle.
    always_comb begin
        w_rsp_hit = '0;
        if (w_rsp) begin
            w_rsp_hit[w_tag_id] = 1'b1;
        end
    end

    // Issue stage: register the granted operands and advance the round-robin pointer.
    always_ff @(posedge I_Clk or negedge I_nReset) begin
        if (!I_nReset) begin
            bus.O_Dp_Valid    <= 1'b0;
            bus.O_Dp_Exp      <= '0;
            bus.O_Dp_Sign_Op1 <= 1'b0;
            bus.O_Dp_Mant_Op1 <= '0;
            bus.O_Dp_Sign_Op2 <= 1'b0;
            bus.O_Dp_Mant_Op2 <= '0;
            r_dp_id           <= '0;
            r_rr_ptr          <= '0;
        end else if (w_found) begin
            bus.O_Dp_Valid    <= 1'b1;
            bus.O_Dp_Exp      <= bus.I_Req_Exp[w_grant_id*EW +: EW];
            bus.O_Dp_Sign_Op1 <= bus.I_Req_Sign_Op1[w_grant_id];
            bus.O_Dp_Mant_Op1 <= bus.I_Req_Mant_Op1[w_grant_id*MNW +: MNW];
            bus.O_Dp_Sign_Op2 <= bus.I_Req_Sign_Op2[w_grant_id] ^ bus.I_Req_Sub[w_grant_id];
            bus.O_Dp_Mant_Op2 <= bus.I_Req_Mant_Op2[w_grant_id*MNW +: MNW];
            r_dp_id           <= w_grant_id;
            r_rr_ptr          <= (w_grant_id == LAST_IDX) ? '0 : w_grant_id + 1'b1;
        end else begin
            bus.O_Dp_Valid    <= 1'b0;
        end
    end

    // Tag pipe follows the issued op through the datapath, one stage per datapath cycle.
    always_ff @(posedge I_Clk or negedge I_nReset) begin
        if (!I_nReset) begin
            r_tag_vld <= '0;
            for (int unsigned s = 0; s < DP_LATENCY; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            r_tag_vld[0] <= bus.O_Dp_Valid;
            r_tag_id[0]  <= r_dp_id;
            for (int unsigned s = 1; s < DP_LATENCY; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
        end
    end

    // Result routing back to the issuer; a tag/valid disagreement raises the sticky error.
    always_ff @(posedge I_Clk or negedge I_nReset) begin
        if (!I_nReset) begin
            bus.O_Rsp_Valid <= '0;
            bus.O_Rsp_Id    <= '0;
            bus.O_Rsp_Sign  <= 1'b0;
            bus.O_Rsp_Exp   <= '0;
            bus.O_Rsp_Mant  <= '0;
            bus.O_Err       <= 1'b0;
        end else begin
            bus.O_Rsp_Valid <= w_rsp_hit;
            if (w_rsp) begin
                bus.O_Rsp_Id   <= w_tag_id;
                bus.O_Rsp_Sign <= bus.I_Dp_Sign;
                bus.O_Rsp_Exp  <= bus.I_Dp_Exp;
                bus.O_Rsp_Mant <= bus.I_Dp_Mant;
            end
            if (bus.I_Dp_Valid != w_tag_vld) begin
                bus.O_Err <= 1'b1;
            end
        end
    end

    // Per-requester credit counters: +1 on accept, -1 on response, unchanged when both.
    always_ff @(posedge I_Clk or negedge I_nReset) begin
        if (!I_nReset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i] && !w_rsp_hit[i]) begin
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                end else if (!w_grant[i] && w_rsp_hit[i] && r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - 4'd1;
                end
            end
        end
    end

`ifdef FPU_ARB_BUSY_CNT_EN
    // Saturating activity counters: datapath-busy cycles and requested-but-not-granted cycles.
    always_ff @(posedge I_Clk or negedge I_nReset) begin
        if (!I_nReset) begin
            O_Busy_Cnt  <= '0;
            O_Stall_Cnt <= '0;
        end else begin
            if (bus.O_Dp_Valid && O_Busy_Cnt != '1) begin
                O_Busy_Cnt <= O_Busy_Cnt + 32'd1;
            end
            if ((|bus.I_Req_Valid) && !w_found && O_Stall_Cnt != '1) begin
                O_Stall_Cnt <= O_Stall_Cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// tb_fpu_addsub_arbiter: directed checks of arbitration, routing, credits, error and reset.
module tb_fpu_addsub_arbiter;
    localparam int NR  = 4;
    localparam int EW  = 8;
    localparam int MNW = 24;
    localparam int RW  = 25;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_addsub_arbiter_if #(.PRECISION(32), .NUM_REQ(NR)) bus ();

`ifdef FPU_ARB_BUSY_CNT_EN
    logic [31:0] busy_cnt;
    logic [31:0] stall_cnt;
`endif

    fpu_addsub_arbiter #(
        .PRECISION(32),
        .NUM_REQ(NR),
        .DP_LATENCY(1),
        .MAX_OUTSTANDING(2)
    ) dut (
        .I_Clk(clk),
        .I_nReset(rst_n),
        .bus(bus)
`ifdef FPU_ARB_BUSY_CNT_EN
        ,
        .O_Busy_Cnt(busy_cnt),
        .O_Stall_Cnt(stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // One-cycle datapath model, or manual injection when dp_auto is low.
    logic          dp_auto = 1'b1;
    logic          inj_vld = 1'b0;
    logic          m_vld   = 1'b0;
    logic          m_sign  = 1'b0;
    logic [EW-1:0] m_exp   = '0;
    logic [RW-1:0] m_mant  = '0;

    always @(posedge clk) begin
        m_vld <= bus.O_Dp_Valid;
        m_exp <= bus.O_Dp_Exp;
        if (bus.O_Dp_Sign_Op1 == bus.O_Dp_Sign_Op2) begin
            m_sign <= bus.O_Dp_Sign_Op1;
            m_mant <= {1'b0, bus.O_Dp_Mant_Op1} + {1'b0, bus.O_Dp_Mant_Op2};
        end else if (bus.O_Dp_Mant_Op1 >= bus.O_Dp_Mant_Op2) begin
            m_sign <= bus.O_Dp_Sign_Op1;
            m_mant <= {1'b0, bus.O_Dp_Mant_Op1} - {1'b0, bus.O_Dp_Mant_Op2};
        end else begin
            m_sign <= bus.O_Dp_Sign_Op2;
            m_mant <= {1'b0, bus.O_Dp_Mant_Op2} - {1'b0, bus.O_Dp_Mant_Op1};
        end
    end

    assign bus.I_Dp_Valid = dp_auto ? m_vld : inj_vld;
    assign bus.I_Dp_Sign  = m_sign;
    assign bus.I_Dp_Exp   = m_exp;
    assign bus.I_Dp_Mant  = m_mant;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int idx, input logic sub, input logic [EW-1:0] e,
                           input logic s1, input logic [MNW-1:0] m1,
                           input logic s2, input logic [MNW-1:0] m2);
        bus.I_Req_Sub[idx]                = sub;
        bus.I_Req_Exp[idx*EW +: EW]       = e;
        bus.I_Req_Sign_Op1[idx]           = s1;
        bus.I_Req_Mant_Op1[idx*MNW +: MNW] = m1;
        bus.I_Req_Sign_Op2[idx]           = s2;
        bus.I_Req_Mant_Op2[idx*MNW +: MNW] = m2;
    endtask

    logic [3:0] rr_exp [8];
    int         rr_id  [8];

    initial begin
        rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_id  = '{1, 2, 3, 0, 1, 2, 3, 0};

        bus.I_Req_Valid    = '0;
        bus.I_Req_Sub      = '0;
        bus.I_Req_Exp      = '0;
        bus.I_Req_Sign_Op1 = '0;
        bus.I_Req_Mant_Op1 = '0;
        bus.I_Req_Sign_Op2 = '0;
        bus.I_Req_Mant_Op2 = '0;

        // Reset state
        tick();
        tick();
        check("rst_dp_valid", 64'(bus.O_Dp_Valid), 64'd0);
        check("rst_rsp_valid", 64'(bus.O_Rsp_Valid), 64'd0);
        check("rst_err", 64'(bus.O_Err), 64'd0);
        check("rst_ready", 64'(bus.O_Req_Ready), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single add on req0: 1.5 + 1.0
        set_req(0, 1'b0, 8'd127, 1'b0, 24'hC00000, 1'b0, 24'h800000);
        bus.I_Req_Valid = 4'b0001;
        #1;
        check("add_ready", 64'(bus.O_Req_Ready), 64'h1);
        tick();
        bus.I_Req_Valid = '0;
        check("add_dp_valid", 64'(bus.O_Dp_Valid), 64'd1);
        check("add_dp_exp", 64'(bus.O_Dp_Exp), 64'd127);
        check("add_dp_m1", 64'(bus.O_Dp_Mant_Op1), 64'hC00000);
        check("add_dp_m2", 64'(bus.O_Dp_Mant_Op2), 64'h800000);
        check("add_dp_s2", 64'(bus.O_Dp_Sign_Op2), 64'd0);
        tick();
        check("add_rsp_early", 64'(bus.O_Rsp_Valid), 64'd0);
        tick();
        check("add_rsp_valid", 64'(bus.O_Rsp_Valid), 64'h1);
        check("add_rsp_id", 64'(bus.O_Rsp_Id), 64'd0);
        check("add_rsp_mant", 64'(bus.O_Rsp_Mant), 64'h1400000);
        check("add_rsp_exp", 64'(bus.O_Rsp_Exp), 64'd127);
        tick();
        check("add_rsp_once", 64'(bus.O_Rsp_Valid), 64'd0);
        check("add_dp_idle", 64'(bus.O_Dp_Valid), 64'd0);

        // Same operands as subtract: op2 sign flips on issue
        set_req(0, 1'b1, 8'd127, 1'b0, 24'hC00000, 1'b0, 24'h800000);
        bus.I_Req_Valid = 4'b0001;
        #1;
        check("sub_ready", 64'(bus.O_Req_Ready), 64'h1);
        tick();
        bus.I_Req_Valid = '0;
        check("sub_dp_s2", 64'(bus.O_Dp_Sign_Op2), 64'd1);
        tick();
        tick();
        check("sub_rsp_valid", 64'(bus.O_Rsp_Valid), 64'h1);
        check("sub_rsp_id", 64'(bus.O_Rsp_Id), 64'd0);
        check("sub_rsp_mant", 64'(bus.O_Rsp_Mant), 64'h400000);
        check("sub_rsp_sign", 64'(bus.O_Rsp_Sign), 64'd0);
        tick();

        // All four requesting: pointer sits at 1 after the two req0 accepts
        for (int i = 0; i < NR; i++) begin
            set_req(i, 1'b0, 8'd127, 1'b0, 24'hC00000, 1'b0, 24'h800000);
        end
        bus.I_Req_Valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            #1;
            check($sformatf("rr_grant%0d", n), 64'(bus.O_Req_Ready), 64'(rr_exp[n]));
            if (n >= 1) begin
                check($sformatf("rr_dp_valid%0d", n), 64'(bus.O_Dp_Valid), 64'd1);
            end
            if (n >= 3) begin
                check($sformatf("rr_rsp_id%0d", n), 64'(bus.O_Rsp_Id), 64'(rr_id[n-3]));
                check($sformatf("rr_rsp_valid%0d", n), 64'(bus.O_Rsp_Valid), 64'(rr_exp[n-3]));
            end
            tick();
        end
        bus.I_Req_Valid = '0;
        repeat (4) tick();
        check("rr_drained_err", 64'(bus.O_Err), 64'd0);

        // Credit limit on req2 with responses returning two cycles after accept
        bus.I_Req_Valid = 4'b0100;
        for (int n = 0; n < 9; n++) begin
            #1;
            check($sformatf("credit_ready%0d", n), 64'(bus.O_Req_Ready),
                  (n % 3 == 2) ? 64'd0 : 64'h4);
            tick();
        end
        bus.I_Req_Valid = '0;
        repeat (4) tick();

        // Result with no tag in flight
        dp_auto = 1'b0;
        inj_vld = 1'b1;
        tick();
        inj_vld = 1'b0;
        check("err_set", 64'(bus.O_Err), 64'd1);
        check("err_no_rsp", 64'(bus.O_Rsp_Valid), 64'd0);
        repeat (3) tick();
        check("err_sticky", 64'(bus.O_Err), 64'd1);
        rst_n = 1'b0;
        #1;
        check("err_cleared", 64'(bus.O_Err), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset with two ops in flight
        set_req(1, 1'b0, 8'd127, 1'b0, 24'hC00000, 1'b0, 24'h800000);
        bus.I_Req_Valid = 4'b0011;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_dp_valid", 64'(bus.O_Dp_Valid), 64'd0);
        check("midrst_ready", 64'(bus.O_Req_Ready), 64'd0);
        check("midrst_rsp", 64'(bus.O_Rsp_Valid), 64'd0);
        check("midrst_err", 64'(bus.O_Err), 64'd0);
        bus.I_Req_Valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
        inj_vld = 1'b1;
        tick();
        inj_vld = 1'b0;
        check("stale_err", 64'(bus.O_Err), 64'd1);
        check("stale_no_rsp", 64'(bus.O_Rsp_Valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
